// File: rtl/bot_update_handshake.sv
// Clock-domain handshake between the Rojobot update strobe and mfp_sys (clk_50).
// Synchronizes the strobe, snapshots bot info on its rising edge, holds a pending flag until ack.
module bot_update_handshake #(
    parameter int SYNC_STAGES = 2,
    parameter int INFO_W      = 32,
    parameter int MISS_W      = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              upd_sysregs_in,
    input  logic [INFO_W-1:0] bot_info_in,
    input  logic              int_ack,
    input  logic              clr_missed,
    output logic [INFO_W-1:0] bot_info_out,
    output logic              bot_update_sync,
    output logic              upd_pulse,
    output logic [MISS_W-1:0] missed_cnt
);

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } state_t;

    localparam logic [MISS_W-1:0] MISS_MAX = {MISS_W{1'b1}};
    localparam logic [MISS_W-1:0] MISS_ONE = {{(MISS_W-1){1'b0}}, 1'b1};

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   prev_r;
    logic                   edge_s;
    logic                   miss_inc_s;
    state_t                 state_r;
    state_t                 state_nxt_s;

    // Synchronizer chain plus edge-detect history register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_r <= '0;
            prev_r <= 1'b0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], upd_sysregs_in};
            prev_r <= sync_r[SYNC_STAGES-1];
        end
    end

    assign edge_s = sync_r[SYNC_STAGES-1] & ~prev_r;

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state: a new update always wins over a simultaneous ack
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (edge_s) begin
                    state_nxt_s = PENDING;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            PENDING: begin
                if (edge_s) begin
                    state_nxt_s = PENDING;
                end else if (int_ack) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = PENDING;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // FSM outputs: pending flag and missed-update strobe
    always_comb begin
        bot_update_sync = 1'b0;
        miss_inc_s      = 1'b0;
        case (state_r)
            IDLE: begin
                bot_update_sync = 1'b0;
                miss_inc_s      = 1'b0;
            end
            PENDING: begin
                bot_update_sync = 1'b1;
                miss_inc_s      = edge_s & ~int_ack;
            end
            default: begin
                bot_update_sync = 1'b0;
                miss_inc_s      = 1'b0;
            end
        endcase
    end

    // Snapshot register and one-cycle update pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bot_info_out <= '0;
            upd_pulse    <= 1'b0;
        end else begin
            upd_pulse <= edge_s;
            if (edge_s) begin
                bot_info_out <= bot_info_in;
            end else begin
                bot_info_out <= bot_info_out;
            end
        end
    end

    // Saturating missed-update counter; clear has priority over increment
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            missed_cnt <= '0;
        end else if (clr_missed) begin
            missed_cnt <= '0;
        end else if (miss_inc_s && (missed_cnt != MISS_MAX)) begin
            missed_cnt <= missed_cnt + MISS_ONE;
        end else begin
            missed_cnt <= missed_cnt;
        end
    end

endmodule
